// File: rtl/axi_led_pkg.sv
// Shared constants and types for the AXI-Lite LED sequencer: response codes,
// sequencing modes, controller states and the LED register address.
package axi_led_pkg;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [1:0]  RESP_DECERR  = 2'b11;

    localparam logic [31:0] LED_REG_ADDR = 32'h0;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'b00,
        MODE_COUNT  = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RESP,
        ST_WAIT
    } state_e;

    // The reserved encoding behaves as rotate, so it is never stored as-is.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == MODE_RSVD) ? MODE_ROTATE : mode_e'(raw);
    endfunction

endpackage

// File: rtl/axi_lite_write_master.sv
// Single-transaction AXI-Lite write master: issues AW and W together, retires
// each independently, then collects exactly one B response.
module axi_lite_write_master
    import axi_led_pkg::*;
#(
    parameter int AXI_ADDR_BW_p = 4
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [AXI_ADDR_BW_p-1:0] addr,
    input  logic [31:0]              data,
    output logic [AXI_ADDR_BW_p-1:0] awaddr,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready,
    output logic                     req_done,
    output logic                     rsp_done,
    output logic                     rsp_err
);

    logic aw_hs;
    logic w_hs;

    always_comb begin
        aw_hs    = awvalid & awready;
        w_hs     = wvalid & wready;
        // Both channels retired: each is either already low or handshaking now.
        req_done = (awvalid | wvalid) & (~awvalid | awready) & (~wvalid | wready);
        rsp_done = bready & bvalid;
        rsp_err  = rsp_done & (bresp != RESP_OKAY);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr  <= '0;
            awvalid <= 1'b0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            bready  <= 1'b0;
        end else begin
            if (start) begin
                awaddr  <= addr;
                wdata   <= data;
                awvalid <= 1'b1;
                wvalid  <= 1'b1;
            end else begin
                if (aw_hs) awvalid <= 1'b0;
                if (w_hs)  wvalid  <= 1'b0;
            end

            if (req_done)      bready <= 1'b1;
            else if (rsp_done) bready <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_led_sequencer.sv
// LED pattern sequencer: writes a rotating, counting or blinking pattern to an
// AXI-Lite LED register, pausing a programmable number of cycles between writes.
module axi_led_sequencer
    import axi_led_pkg::*;
#(
    parameter int AXI_ADDR_BW_p = 4,
    parameter int LED_NBR_p     = 32,
    parameter int CNT_BW_p      = 24
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic [1:0]               i_mode,
    input  logic [CNT_BW_p-1:0]      i_period,
    input  logic                     i_error_clr,
    output logic [AXI_ADDR_BW_p-1:0] o_axi_awaddr,
    output logic                     o_axi_awvalid,
    input  logic                     i_axi_awready,
    output logic [31:0]              o_axi_wdata,
    output logic                     o_axi_wvalid,
    input  logic                     i_axi_wready,
    input  logic [1:0]               i_axi_bresp,
    input  logic                     i_axi_bvalid,
    output logic                     o_axi_bready,
    output logic                     o_busy,
    output logic                     o_error,
    output logic [LED_NBR_p-1:0]     o_pattern
);

    state_e                state_q, state_next;
    mode_e                 mode_q, mode_next;
    logic [LED_NBR_p-1:0]  pattern_q, pattern_next;
    logic [CNT_BW_p-1:0]   counter_q, counter_next;
    logic                  error_q, error_next;
    logic                  stop_q, stop_next;
    logic                  start;
    logic                  req_done;
    logic                  rsp_done;
    logic                  rsp_err;

    function automatic logic [LED_NBR_p-1:0] load_pattern(input mode_e m);
        case (m)
            MODE_COUNT: return '0;
            MODE_BLINK: return '1;
            default:    return LED_NBR_p'(1);
        endcase
    endfunction

    function automatic logic [LED_NBR_p-1:0] advance_pattern(input logic [LED_NBR_p-1:0] p,
                                                             input mode_e                m);
        case (m)
            MODE_COUNT: return p + LED_NBR_p'(1);
            MODE_BLINK: return ~p;
            default:    return (p << 1) | (p >> (LED_NBR_p - 1));
        endcase
    endfunction

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state_q;
        mode_next    = mode_q;
        pattern_next = pattern_q;
        counter_next = counter_q;
        stop_next    = stop_q;
        start        = 1'b0;
        error_next   = (error_q & ~i_error_clr) | rsp_err;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    mode_next    = decode_mode(i_mode);
                    pattern_next = load_pattern(mode_next);
                    stop_next    = 1'b0;
                    start        = 1'b1;
                    state_next   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!i_enable) stop_next = 1'b1;
                if (req_done)  state_next = ST_RESP;
            end
            ST_RESP: begin
                if (!i_enable) stop_next = 1'b1;
                if (rsp_done) begin
                    counter_next = i_period;
                    // A disable seen at any point during the transaction ends the run here.
                    state_next   = (stop_q || !i_enable) ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_enable) begin
                    state_next = ST_IDLE;
                end else if (counter_q == '0) begin
                    pattern_next = advance_pattern(pattern_q, mode_q);
                    start        = 1'b1;
                    state_next   = ST_WRITE;
                end else begin
                    counter_next = counter_q - CNT_BW_p'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_ROTATE;
            pattern_q <= '0;
            counter_q <= '0;
            error_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_next;
            mode_q    <= mode_next;
            pattern_q <= pattern_next;
            counter_q <= counter_next;
            error_q   <= error_next;
            stop_q    <= stop_next;
        end
    end

    axi_lite_write_master #(
        .AXI_ADDR_BW_p (AXI_ADDR_BW_p)
    ) u_write_master (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr     (AXI_ADDR_BW_p'(LED_REG_ADDR)),
        .data     (32'(pattern_next)),
        .awaddr   (o_axi_awaddr),
        .awvalid  (o_axi_awvalid),
        .awready  (i_axi_awready),
        .wdata    (o_axi_wdata),
        .wvalid   (o_axi_wvalid),
        .wready   (i_axi_wready),
        .bresp    (i_axi_bresp),
        .bvalid   (i_axi_bvalid),
        .bready   (o_axi_bready),
        .req_done (req_done),
        .rsp_done (rsp_done),
        .rsp_err  (rsp_err)
    );

    assign o_busy    = (state_q != ST_IDLE);
    assign o_error   = error_q;
    assign o_pattern = pattern_q;

endmodule

// File: tb/tb_axi_led_sequencer.sv
// Directed bench for axi_led_sequencer (4 LEDs) with a behavioural AXI-Lite
// slave whose ready delays and error response are set per scenario.
module tb_axi_led_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [1:0]  i_mode;
    logic [23:0] i_period;
    logic        i_error_clr;
    logic [3:0]  o_axi_awaddr;
    logic        o_axi_awvalid;
    logic        i_axi_awready = 1'b0;
    logic [31:0] o_axi_wdata;
    logic        o_axi_wvalid;
    logic        i_axi_wready  = 1'b0;
    logic [1:0]  i_axi_bresp   = 2'b00;
    logic        i_axi_bvalid  = 1'b0;
    logic        o_axi_bready;
    logic        o_busy;
    logic        o_error;
    logic [3:0]  o_pattern;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave knobs and bookkeeping
    int aw_delay = 0;
    int w_delay  = 0;
    int err_idx  = -1;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int aw_hs_n  = 0;
    int w_hs_n   = 0;
    int b_hs_n   = 0;
    int cyc      = 0;
    logic got_aw = 1'b0;
    logic got_w  = 1'b0;
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always #5 clk = ~clk;

    axi_led_sequencer #(
        .AXI_ADDR_BW_p (4),
        .LED_NBR_p     (4),
        .CNT_BW_p      (24)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_mode        (i_mode),
        .i_period      (i_period),
        .i_error_clr   (i_error_clr),
        .o_axi_awaddr  (o_axi_awaddr),
        .o_axi_awvalid (o_axi_awvalid),
        .i_axi_awready (i_axi_awready),
        .o_axi_wdata   (o_axi_wdata),
        .o_axi_wvalid  (o_axi_wvalid),
        .i_axi_wready  (i_axi_wready),
        .i_axi_bresp   (i_axi_bresp),
        .i_axi_bvalid  (i_axi_bvalid),
        .o_axi_bready  (o_axi_bready),
        .o_busy        (o_busy),
        .o_error       (o_error),
        .o_pattern     (o_pattern)
    );

    // Slave drives its responses on the falling edge, away from the DUT's sampling edge.
    always @(negedge clk) begin
        if (o_axi_awvalid) begin
            i_axi_awready = (aw_cnt >= aw_delay);
            aw_cnt++;
        end else begin
            i_axi_awready = 1'b0;
            aw_cnt = 0;
        end
        if (o_axi_wvalid) begin
            i_axi_wready = (w_cnt >= w_delay);
            w_cnt++;
        end else begin
            i_axi_wready = 1'b0;
            w_cnt = 0;
        end
        i_axi_bvalid = got_aw && got_w;
        i_axi_bresp  = (b_hs_n == err_idx) ? 2'b10 : 2'b00;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            got_aw <= 1'b0;
            got_w  <= 1'b0;
        end else begin
            if (o_axi_awvalid && i_axi_awready) begin
                got_aw  <= 1'b1;
                aw_hs_n <= aw_hs_n + 1;
            end
            if (o_axi_wvalid && i_axi_wready) begin
                got_w  <= 1'b1;
                w_hs_n <= w_hs_n + 1;
                wr_data.push_back(o_axi_wdata);
                wr_cyc.push_back(cyc);
            end
            if (i_axi_bvalid && o_axi_bready) begin
                got_aw <= 1'b0;
                got_w  <= 1'b0;
                b_hs_n <= b_hs_n + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_writes(input string tag, input int n, input int limit);
        int k = 0;
        while (wr_data.size() < n && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(wr_data.size()), 32'(n));
    endtask

    task automatic wait_bresp(input string tag, input int n, input int limit);
        int k = 0;
        while (b_hs_n < n && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(b_hs_n), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while (o_busy && k < limit) begin
            tick();
            k++;
        end
        check(tag, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int base;
        int aw0;
        int b0;
        int w0;
        logic [31:0] rot_exp[5];

        rot_exp = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};

        rst         = 1'b1;
        i_enable    = 1'b0;
        i_mode      = 2'b00;
        i_period    = '0;
        i_error_clr = 1'b0;
        tick();
        tick();
        check("rst_busy",    32'(o_busy),        32'd0);
        check("rst_pattern", 32'(o_pattern),     32'd0);
        check("rst_awvalid", 32'(o_axi_awvalid), 32'd0);
        check("rst_wvalid",  32'(o_axi_wvalid),  32'd0);
        check("rst_bready",  32'(o_axi_bready),  32'd0);
        check("rst_error",   32'(o_error),       32'd0);
        check("rst_awaddr",  32'(o_axi_awaddr),  32'd0);
        check("rst_wdata",   o_axi_wdata,        32'd0);
        rst = 1'b0;
        tick();

        // Rotate, period 2, slave always ready; mode change mid-run is ignored
        base = wr_data.size();
        aw0  = aw_hs_n;
        b0   = b_hs_n;
        i_mode   = 2'b00;
        i_period = 24'd2;
        i_enable = 1'b1;
        tick();
        check("rot_first_awvalid", 32'(o_axi_awvalid), 32'd1);
        check("rot_first_wvalid",  32'(o_axi_wvalid),  32'd1);
        check("rot_first_wdata",   o_axi_wdata,        32'h1);
        check("rot_first_awaddr",  32'(o_axi_awaddr),  32'd0);
        check("rot_first_pattern", 32'(o_pattern),     32'h1);
        check("rot_first_busy",    32'(o_busy),        32'd1);
        check("rot_first_bready",  32'(o_axi_bready),  32'd0);
        i_mode = 2'b01;
        tick();
        check("rot_resp_bready",   32'(o_axi_bready),  32'd1);
        check("rot_resp_awvalid",  32'(o_axi_awvalid), 32'd0);
        check("rot_resp_wvalid",   32'(o_axi_wvalid),  32'd0);
        wait_writes("rot_count", base + 5, 100);
        for (int i = 0; i < 5; i++) begin
            if (base + i < wr_data.size()) begin
                check($sformatf("rot_wdata%0d", i), wr_data[base + i], rot_exp[i]);
            end
        end
        for (int i = 1; i < 5; i++) begin
            if (base + i < wr_cyc.size()) begin
                check($sformatf("rot_spacing%0d", i),
                      32'(wr_cyc[base + i] - wr_cyc[base + i - 1]), 32'd5);
            end
        end
        i_enable = 1'b0;
        wait_idle("rot_idle", 50);
        check("rot_aw_total", 32'(aw_hs_n - aw0), 32'd5);
        check("rot_b_total",  32'(b_hs_n - b0),   32'd5);
        check("rot_error",    32'(o_error),       32'd0);

        // awready held off 3 cycles, wready immediate
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        b0  = b_hs_n;
        aw_delay = 3;
        i_mode   = 2'b00;
        i_period = 24'd50;
        i_enable = 1'b1;
        tick();
        check("awd_awvalid0", 32'(o_axi_awvalid), 32'd1);
        check("awd_wvalid0",  32'(o_axi_wvalid),  32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("awd_awvalid%0d", i), 32'(o_axi_awvalid), 32'd1);
            check($sformatf("awd_awaddr%0d", i),  32'(o_axi_awaddr),  32'd0);
            check($sformatf("awd_wvalid%0d", i),  32'(o_axi_wvalid),  32'd0);
            check($sformatf("awd_bready%0d", i),  32'(o_axi_bready),  32'd0);
        end
        tick();
        check("awd_awvalid_drop", 32'(o_axi_awvalid), 32'd0);
        check("awd_bready",       32'(o_axi_bready),  32'd1);
        tick();
        check("awd_wait_bready",  32'(o_axi_bready),  32'd0);
        check("awd_wait_busy",    32'(o_busy),        32'd1);
        i_enable = 1'b0;
        tick();
        check("awd_wait_to_idle", 32'(o_busy),           32'd0);
        check("awd_aw_one",       32'(aw_hs_n - aw0),    32'd1);
        check("awd_w_one",        32'(w_hs_n - w0),      32'd1);
        check("awd_b_one",        32'(b_hs_n - b0),      32'd1);
        aw_delay = 0;

        // Count mode, wrap 15 -> 0, o_pattern follows every write
        base = wr_data.size();
        i_mode   = 2'b01;
        i_period = 24'd0;
        i_enable = 1'b1;
        for (int k = 0; k < 17; k++) begin
            wait_writes($sformatf("cnt_n%0d", k), base + k + 1, 20);
            if (base + k < wr_data.size()) begin
                check($sformatf("cnt_wdata%0d", k), wr_data[base + k], 32'(k % 16));
            end
            check($sformatf("cnt_pattern%0d", k), 32'(o_pattern), 32'(k % 16));
        end
        i_enable = 1'b0;
        wait_idle("cnt_idle", 50);

        // SLVERR on the second write, sticky, then clear racing a new SLVERR
        b0 = b_hs_n;
        err_idx  = b0 + 1;
        i_mode   = 2'b10;
        i_period = 24'd1;
        i_enable = 1'b1;
        wait_bresp("err_b1", b0 + 1, 30);
        check("err_after_ok", 32'(o_error), 32'd0);
        wait_bresp("err_b2", b0 + 2, 30);
        check("err_set", 32'(o_error), 32'd1);
        wait_bresp("err_b3", b0 + 3, 30);
        check("err_sticky", 32'(o_error), 32'd1);
        i_error_clr = 1'b1;
        tick();
        i_error_clr = 1'b0;
        check("err_cleared", 32'(o_error), 32'd0);
        err_idx = b_hs_n;
        for (int k = 0; k < 30 && !o_axi_bready; k++) tick();
        check("err_race_bready", 32'(o_axi_bready), 32'd1);
        i_error_clr = 1'b1;
        tick();
        i_error_clr = 1'b0;
        check("err_race_b", 32'(b_hs_n), 32'(err_idx + 1));
        check("err_race_wins", 32'(o_error), 32'd1);
        i_enable = 1'b0;
        wait_idle("err_idle", 50);
        i_error_clr = 1'b1;
        tick();
        i_error_clr = 1'b0;
        check("err_clr_idle", 32'(o_error), 32'd0);

        // Enable dropped mid-WRITE (reserved mode acts as rotate)
        aw0 = aw_hs_n;
        w0  = w_hs_n;
        b0  = b_hs_n;
        aw_delay = 2;
        i_mode   = 2'b11;
        i_period = 24'd3;
        i_enable = 1'b1;
        tick();
        check("dis_pattern_rsvd", 32'(o_pattern),     32'h1);
        check("dis_awvalid",      32'(o_axi_awvalid), 32'd1);
        i_enable = 1'b0;
        wait_idle("dis_idle", 30);
        check("dis_aw_one",  32'(aw_hs_n - aw0),   32'd1);
        check("dis_w_one",   32'(w_hs_n - w0),     32'd1);
        check("dis_b_one",   32'(b_hs_n - b0),     32'd1);
        check("dis_bready",  32'(o_axi_bready),    32'd0);
        check("dis_awvalid_low", 32'(o_axi_awvalid), 32'd0);

        // Reset while stuck in WRITE abandons the transaction
        aw_delay = 5;
        i_mode   = 2'b00;
        i_enable = 1'b1;
        tick();
        check("rw_awvalid", 32'(o_axi_awvalid), 32'd1);
        tick();
        check("rw_awvalid_hold", 32'(o_axi_awvalid), 32'd1);
        rst      = 1'b1;
        i_enable = 1'b0;
        tick();
        check("rw_awvalid_rst", 32'(o_axi_awvalid), 32'd0);
        check("rw_wvalid_rst",  32'(o_axi_wvalid),  32'd0);
        check("rw_pattern_rst", 32'(o_pattern),     32'd0);
        check("rw_busy_rst",    32'(o_busy),        32'd0);
        check("rw_bready_rst",  32'(o_axi_bready),  32'd0);
        rst = 1'b0;
        aw_delay = 0;
        tick();
        check("rw_idle_after", 32'(o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
